// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared 16x16 signed multiplier.
// Accepts one command at a time, issues it to the multiplier, waits for the
// result (or aborts after TIMEOUT cycles) and holds the response until taken.
module mult_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0
  input  logic        cmd0_valid,
  output logic        cmd0_ready,
  input  logic [15:0] cmd0_a,
  input  logic [15:0] cmd0_b,
  input  logic        cmd0_a_parity,
  input  logic        cmd0_b_parity,
  // requester 1
  input  logic        cmd1_valid,
  output logic        cmd1_ready,
  input  logic [15:0] cmd1_a,
  input  logic [15:0] cmd1_b,
  input  logic        cmd1_a_parity,
  input  logic        cmd1_b_parity,
  // shared multiplier
  output logic        m_req,
  output logic [15:0] m_arg_a,
  output logic [15:0] m_arg_b,
  output logic        m_arg_a_parity,
  output logic        m_arg_b_parity,
  input  logic        m_ack,
  input  logic        m_result_rdy,
  input  logic [31:0] m_result,
  input  logic        m_result_parity,
  input  logic        m_arg_parity_error,
  // response
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_result_parity,
  output logic        rsp_parity_error,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Last cycle in which a result may still be accepted; the count reaches
  // TIMEOUT at the end of it.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StRsp} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            id_q, id_d;
  logic [15:0]     arg_a_q, arg_a_d, arg_b_q, arg_b_d;
  logic            arg_ap_q, arg_ap_d, arg_bp_q, arg_bp_d;
  logic [31:0]     res_q, res_d;
  logic            res_p_q, res_p_d, perr_q, perr_d, tmo_q, tmo_d;
  logic            m_req_q, m_req_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d;
  logic            gnt_id;
  logic            capture;

  // Next-state, arbitration, operand latching and response capture.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    arg_a_d    = arg_a_q;
    arg_b_d    = arg_b_q;
    arg_ap_d   = arg_ap_q;
    arg_bp_d   = arg_bp_q;
    res_d      = res_q;
    res_p_d    = res_p_q;
    perr_d     = perr_q;
    tmo_d      = tmo_q;
    cmd0_ready = 1'b0;
    cmd1_ready = 1'b0;
    capture    = 1'b0;
    // Requester 1 wins if it is the only one asking or the pointer favours it.
    gnt_id     = cmd1_valid & (~cmd0_valid | rr_q);

    unique case (state_q)
      StIdle: begin
        if (cmd0_valid | cmd1_valid) begin
          cmd0_ready = ~gnt_id;
          cmd1_ready = gnt_id;
          id_d       = gnt_id;
          arg_a_d    = gnt_id ? cmd1_a : cmd0_a;
          arg_b_d    = gnt_id ? cmd1_b : cmd0_b;
          arg_ap_d   = gnt_id ? cmd1_a_parity : cmd0_a_parity;
          arg_bp_d   = gnt_id ? cmd1_b_parity : cmd0_b_parity;
          cnt_d      = '0;
          state_d    = StReq;
        end
      end
      StReq, StWait: begin
        cnt_d   = cnt_q + CntW'(1);
        // A result is only meaningful once the operands were accepted.
        capture = m_result_rdy & ((state_q == StWait) | m_ack);
        if (capture) begin
          res_d   = m_result;
          res_p_d = m_result_parity;
          perr_d  = m_arg_parity_error;
          tmo_d   = 1'b0;
          state_d = StRsp;
        end else if (cnt_q == CntLast) begin
          res_d   = '0;
          res_p_d = 1'b0;
          perr_d  = 1'b0;
          tmo_d   = 1'b1;
          state_d = StRsp;
        end else if ((state_q == StReq) && m_ack) begin
          state_d = StWait;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          rr_d    = ~id_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    m_req_d     = (state_d == StReq);
    rsp_valid_d = (state_d == StRsp);
    busy_d      = (state_d != StIdle);
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      arg_a_q     <= '0;
      arg_b_q     <= '0;
      arg_ap_q    <= 1'b0;
      arg_bp_q    <= 1'b0;
      res_q       <= '0;
      res_p_q     <= 1'b0;
      perr_q      <= 1'b0;
      tmo_q       <= 1'b0;
      m_req_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      arg_a_q     <= arg_a_d;
      arg_b_q     <= arg_b_d;
      arg_ap_q    <= arg_ap_d;
      arg_bp_q    <= arg_bp_d;
      res_q       <= res_d;
      res_p_q     <= res_p_d;
      perr_q      <= perr_d;
      tmo_q       <= tmo_d;
      m_req_q     <= m_req_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign m_req             = m_req_q;
  assign m_arg_a           = arg_a_q;
  assign m_arg_b           = arg_b_q;
  assign m_arg_a_parity    = arg_ap_q;
  assign m_arg_b_parity    = arg_bp_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_id            = id_q;
  assign rsp_result        = res_q;
  assign rsp_result_parity = res_p_q;
  assign rsp_parity_error  = perr_q;
  assign rsp_timeout       = tmo_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed commands, a reactive multiplier model and a
// per-cycle timeline scoreboard, plus literal expectations per scenario.
module tb_mult_arbiter;

  localparam int TMO = 8;

  logic        clk, rst_n;
  logic        cmd0_valid, cmd0_ready, cmd0_a_parity, cmd0_b_parity;
  logic [15:0] cmd0_a, cmd0_b;
  logic        cmd1_valid, cmd1_ready, cmd1_a_parity, cmd1_b_parity;
  logic [15:0] cmd1_a, cmd1_b;
  logic        m_req, m_arg_a_parity, m_arg_b_parity;
  logic [15:0] m_arg_a, m_arg_b;
  logic        m_ack, m_result_rdy, m_result_parity, m_arg_parity_error;
  logic [31:0] m_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_result_parity, rsp_parity_error, rsp_timeout;
  logic [31:0] rsp_result;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mult_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd0_valid(cmd0_valid), .cmd0_ready(cmd0_ready), .cmd0_a(cmd0_a), .cmd0_b(cmd0_b),
    .cmd0_a_parity(cmd0_a_parity), .cmd0_b_parity(cmd0_b_parity),
    .cmd1_valid(cmd1_valid), .cmd1_ready(cmd1_ready), .cmd1_a(cmd1_a), .cmd1_b(cmd1_b),
    .cmd1_a_parity(cmd1_a_parity), .cmd1_b_parity(cmd1_b_parity),
    .m_req(m_req), .m_arg_a(m_arg_a), .m_arg_b(m_arg_b),
    .m_arg_a_parity(m_arg_a_parity), .m_arg_b_parity(m_arg_b_parity),
    .m_ack(m_ack), .m_result_rdy(m_result_rdy), .m_result(m_result),
    .m_result_parity(m_result_parity), .m_arg_parity_error(m_arg_parity_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_result_parity(rsp_result_parity), .rsp_parity_error(rsp_parity_error),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Multiplier model: acks ack_dly cycles into m_req, returns the product
  // res_dly cycles after the ack (or with the ack when same_cyc is set).
  int unsigned ack_dly = 0;
  int unsigned res_dly = 1;
  bit          same_cyc = 1'b0;

  initial begin : responder
    int unsigned wcnt;
    bit          pend;
    logic [15:0] ra, rb;
    logic        rpa, rpb;
    logic [31:0] prod;
    m_ack = 0; m_result_rdy = 0; m_result = 0; m_result_parity = 0; m_arg_parity_error = 0;
    pend = 0; wcnt = 0;
    ra = 0; rb = 0; rpa = 0; rpb = 0; prod = 0;
    forever begin
      @(posedge clk); #1;
      m_ack = 1'b0;
      m_result_rdy = 1'b0;
      if (!rst_n || !busy) begin
        pend = 0; wcnt = 0;
      end else if (!pend && m_req) begin
        if (wcnt >= ack_dly) begin
          m_ack = 1'b1; pend = 1; wcnt = 0;
          ra = m_arg_a; rb = m_arg_b; rpa = m_arg_a_parity; rpb = m_arg_b_parity;
          if (same_cyc) begin
            prod = {{16{ra[15]}}, ra} * {{16{rb[15]}}, rb};
            m_result = prod; m_result_parity = ^prod;
            m_arg_parity_error = ((^ra) != rpa) || ((^rb) != rpb);
            m_result_rdy = 1'b1; pend = 0;
          end
        end else wcnt++;
      end else if (pend) begin
        if (wcnt >= res_dly) begin
          prod = {{16{ra[15]}}, ra} * {{16{rb[15]}}, rb};
          m_result = prod; m_result_parity = ^prod;
          m_arg_parity_error = ((^ra) != rpa) || ((^rb) != rpb);
          m_result_rdy = 1'b1; pend = 0; wcnt = 0;
        end else wcnt++;
      end
    end
  end

  // Scoreboard: one transaction at a time, tracked as a timeline of
  // accept / ack / response cycles derived from the observed handshakes.
  int          cyc = 0;
  bit          in_fl = 0;
  logic        m_rr = 0;
  logic        mid = 0;
  logic [15:0] ma = 0, mb = 0;
  logic        mpa = 0, mpb = 0;
  int          t_acc = 0, t_ack = -1, t_rsp = -1;
  logic [31:0] e_res = 0;
  logic        e_rp = 0, e_pe = 0, e_to = 0;
  logic        e0, e1, e_req, e_val;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk1("rst_m_req", m_req, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk32("rst_m_args", {m_arg_a, m_arg_b}, 32'h0);
      chk32("rst_m_arg_par", {30'h0, m_arg_a_parity, m_arg_b_parity}, 32'h0);
      chk32("rst_rsp_result", rsp_result, 32'h0);
      chk32("rst_rsp_flags", {28'h0, rsp_id, rsp_result_parity, rsp_parity_error, rsp_timeout},
            32'h0);
      in_fl = 0;
      m_rr  = 0;
    end else begin
      e0    = !in_fl && cmd0_valid && (!cmd1_valid || m_rr == 1'b0);
      e1    = !in_fl && cmd1_valid && (!cmd0_valid || m_rr == 1'b1);
      e_req = in_fl && cyc > t_acc && t_ack < 0 && t_rsp < 0;
      e_val = in_fl && t_rsp >= 0 && cyc >= t_rsp;
      chk1("cmd0_ready", cmd0_ready, e0);
      chk1("cmd1_ready", cmd1_ready, e1);
      chk1("m_req", m_req, e_req);
      chk1("busy", busy, in_fl);
      chk1("rsp_valid", rsp_valid, e_val);
      if (e_req) begin
        chk32("m_args", {m_arg_a, m_arg_b}, {ma, mb});
        chk32("m_arg_par", {30'h0, m_arg_a_parity, m_arg_b_parity}, {30'h0, mpa, mpb});
      end
      if (e_val) begin
        chk1("rsp_id", rsp_id, mid);
        chk32("rsp_result", rsp_result, e_res);
        chk32("rsp_flags", {29'h0, rsp_result_parity, rsp_parity_error, rsp_timeout},
              {29'h0, e_rp, e_pe, e_to});
      end
      if (e0 || e1) begin
        in_fl = 1; mid = e1;
        ma  = e1 ? cmd1_a : cmd0_a;
        mb  = e1 ? cmd1_b : cmd0_b;
        mpa = e1 ? cmd1_a_parity : cmd0_a_parity;
        mpb = e1 ? cmd1_b_parity : cmd0_b_parity;
        t_acc = cyc; t_ack = -1; t_rsp = -1;
      end else if (in_fl) begin
        if (e_val) begin
          if (rsp_ready) begin
            in_fl = 0;
            m_rr  = ~mid;
          end
        end else if (t_rsp < 0 && cyc > t_acc) begin
          if (m_ack && t_ack < 0) t_ack = cyc;
          if (m_result_rdy && t_ack >= 0) begin
            e_res = m_result; e_rp = m_result_parity; e_pe = m_arg_parity_error; e_to = 0;
            t_rsp = cyc + 1;
          end else if (cyc == t_acc + TMO) begin
            e_res = 0; e_rp = 0; e_pe = 0; e_to = 1;
            t_rsp = cyc + 1;
          end
        end
      end
    end
  end

  task automatic send(input logic id, input logic [15:0] a, input logic [15:0] b,
                      input logic pa, input logic pb);
    bit got;
    if (id) begin
      cmd1_valid = 1; cmd1_a = a; cmd1_b = b; cmd1_a_parity = pa; cmd1_b_parity = pb;
    end else begin
      cmd0_valid = 1; cmd0_a = a; cmd0_b = b; cmd0_a_parity = pa; cmd0_b_parity = pb;
    end
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = id ? cmd1_ready : cmd0_ready;
    end
    chk1("send_accepted", got, 1'b1);
    @(posedge clk); #1;
    if (id) cmd1_valid = 0;
    else cmd0_valid = 0;
  endtask

  task automatic take_rsp(input int hold, output logic id, output logic [31:0] res,
                          output logic pe, output logic to);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    chk1("rsp_arrived", seen, 1'b1);
    id = rsp_id; res = rsp_result; pe = rsp_parity_error; to = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk1("hold_busy_no_ready", busy && !cmd0_ready && !cmd1_ready, 1'b1);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic        rid, rpe, rto;
    logic [31:0] rres;
    int          grants[$];
    int          rids[$];
    int          i0, i1, n;
    bit          g0, g1;

    rst_n = 0; rsp_ready = 0;
    cmd0_valid = 0; cmd0_a = 0; cmd0_b = 0; cmd0_a_parity = 0; cmd0_b_parity = 0;
    cmd1_valid = 0; cmd1_a = 0; cmd1_b = 0; cmd1_a_parity = 0; cmd1_b_parity = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;

    // Max positive square.
    send(0, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
    take_rsp(0, rid, rres, rpe, rto);
    chk1("sq_id", rid, 1'b0);
    chk32("sq_result", rres, 32'h3FFF0001);
    chk1("sq_timeout", rto, 1'b0);
    chk1("sq_perr", rpe, 1'b0);

    // Most-negative operand with a bad parity bit.
    send(0, 16'h8000, 16'h0002, 1'b0, 1'b1);
    take_rsp(0, rid, rres, rpe, rto);
    chk1("perr_flag", rpe, 1'b1);
    chk32("perr_result", rres, 32'hFFFF0000);

    // Ack and result in the same cycle.
    same_cyc = 1;
    send(1, 16'hFFFF, 16'h0003, 1'b0, 1'b0);
    take_rsp(0, rid, rres, rpe, rto);
    chk1("same_id", rid, 1'b1);
    chk32("same_result", rres, 32'hFFFFFFFD);
    same_cyc = 0;

    // Both requesters streaming four commands each.
    rsp_ready = 1; i0 = 0; i1 = 0;
    cmd0_valid = 1; cmd0_a = 16'h0001; cmd0_b = 16'h0100;
    cmd0_a_parity = ^cmd0_a; cmd0_b_parity = ^cmd0_b;
    cmd1_valid = 1; cmd1_a = 16'h0010; cmd1_b = 16'hFFFE;
    cmd1_a_parity = ^cmd1_a; cmd1_b_parity = ^cmd1_b;
    for (int c = 0; c < 300 && rids.size() < 8; c++) begin
      @(negedge clk);
      g0 = cmd0_ready; g1 = cmd1_ready;
      if (g0) grants.push_back(0);
      if (g1) grants.push_back(1);
      if (rsp_valid && rsp_ready) rids.push_back(int'(rsp_id));
      @(posedge clk); #1;
      if (g0) begin
        i0++;
        if (i0 < 4) begin cmd0_a = 16'(i0 + 1); cmd0_a_parity = ^cmd0_a; end
        else cmd0_valid = 0;
      end
      if (g1) begin
        i1++;
        if (i1 < 4) begin cmd1_a = 16'(i1 + 16); cmd1_a_parity = ^cmd1_a; end
        else cmd1_valid = 0;
      end
    end
    rsp_ready = 0;
    chk32("pair_grants", grants.size(), 8);
    chk32("pair_rsps", rids.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < grants.size()) chk32("pair_grant_order", grants[i], i & 1);
      if (i < rids.size()) chk32("pair_rsp_order", rids[i], i & 1);
    end

    // Response back-pressure with the other requester waiting.
    send(0, 16'h1234, 16'h0010, ^16'h1234, ^16'h0010);
    cmd1_valid = 1; cmd1_a = 16'h0003; cmd1_b = 16'h0005; cmd1_a_parity = 0; cmd1_b_parity = 0;
    take_rsp(5, rid, rres, rpe, rto);
    chk32("bp_result", rres, 32'h00012340);
    send(1, 16'h0003, 16'h0005, 1'b0, 1'b0);
    take_rsp(0, rid, rres, rpe, rto);
    chk1("bp_second_id", rid, 1'b1);
    chk32("bp_second_result", rres, 32'h0000000F);

    // Multiplier never acks: abort after TIMEOUT cycles.
    ack_dly = 1000;
    send(0, 16'h0003, 16'h0004, 1'b0, 1'b1);
    @(negedge clk);
    chk1("tmo_m_req_up", m_req, 1'b1);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk32("tmo_latency", n, TMO);
    chk1("tmo_m_req_down", m_req, 1'b0);
    take_rsp(0, rid, rres, rpe, rto);
    chk1("tmo_flag", rto, 1'b1);
    chk32("tmo_result", rres, 32'h0);
    ack_dly = 0;

    // Result on the last allowed cycle still wins.
    res_dly = 6;
    send(1, 16'h0005, 16'h0006, 1'b0, 1'b0);
    take_rsp(0, rid, rres, rpe, rto);
    chk1("edge_tmo_flag", rto, 1'b0);
    chk32("edge_result", rres, 32'h0000001E);

    // Result one cycle late: aborted, and the late pulse is ignored.
    res_dly = 7;
    send(0, 16'h0002, 16'h0002, 1'b1, 1'b1);
    take_rsp(0, rid, rres, rpe, rto);
    chk1("late_tmo_flag", rto, 1'b1);
    chk32("late_result", rres, 32'h0);

    // Reset pulse while waiting for the result.
    res_dly = 5;
    send(1, 16'h0007, 16'h0007, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 0;
    @(negedge clk);
    chk1("mid_rst_m_req", m_req, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    @(posedge clk); #3;
    rst_n = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk32("mid_rst_no_rsp", n, 0);
    res_dly = 1;
    @(posedge clk); #1;
    send(0, 16'h0100, 16'h0100, 1'b1, 1'b1);
    take_rsp(0, rid, rres, rpe, rto);
    chk1("post_rst_id", rid, 1'b0);
    chk32("post_rst_result", rres, 32'h00010000);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max cycles from m_req assertion to m_result_rdy before abort (legal range 1..65535).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset; clk is the single clock, rst_n asynchronous, active-low.
REQ-004 cmd0_valid / cmd1_valid  input  1  requester 0/1 holds a multiply command.
REQ-005 cmd0_ready / cmd1_ready  output  1  single-cycle accept strobe to requester 0/1.
REQ-006 cmd0_a, cmd0_b / cmd1_a, cmd1_b  input  16  signed operands of requester 0/1.
REQ-007 cmd0_a_parity, cmd0_b_parity / cmd1_a_parity, cmd1_b_parity  input  1  operand parity bits, forwarded unmodified.
REQ-008 m_req  output  1  request to shared multiplier.
REQ-009 m_arg_a, m_arg_b  output  16  operands to multiplier; m_arg_a_parity, m_arg_b_parity  output  1  their parity bits.
REQ-010 m_ack  input  1  multiplier accepted operands (one-cycle pulse).
REQ-011 m_result_rdy  input  1  one-cycle pulse: m_result, m_result_parity, m_arg_parity_error valid.
REQ-012 m_result  input  32  signed product; m_result_parity  input  1; m_arg_parity_error  input  1.
REQ-013 rsp_valid  output  1  response held for requester identified by rsp_id.
REQ-014 rsp_ready  input  1  response consumer accepts.
REQ-015 rsp_id  output  1  served requester; rsp_result  output  32; rsp_result_parity  output  1; rsp_parity_error  output  1; rsp_timeout  output  1.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, REQ, WAIT, RSP; all outputs registered except cmdN_ready.
REQ-018 IDLE: if any cmdN_valid, grant one requester, assert its cmdN_ready combinationally that cycle, latch its a/b/parities, go REQ next cycle.
REQ-019 Arbitration round-robin: rr pointer names priority requester; both valid -> pointer wins; one valid -> that one wins.
REQ-020 Pointer updates to (served id XOR 1) on RSP handshake only; never moves while busy.
REQ-021 REQ: m_req=1 with latched operands stable; on m_ack go WAIT, m_req low from next cycle.
REQ-022 WAIT: on m_result_rdy capture m_result, m_result_parity, m_arg_parity_error into rsp_* , rsp_timeout=0, go RSP.
REQ-023 m_ack and m_result_rdy same cycle in REQ: capture result, go RSP directly.
REQ-024 Timeout counter ($clog2(TIMEOUT+1) bits) clears on entering REQ, increments each cycle in REQ/WAIT; reaching TIMEOUT without m_result_rdy -> rsp_result=0, rsp_result_parity=0, rsp_parity_error=0, rsp_timeout=1, m_req=0, go RSP.
REQ-025 m_result_rdy arriving on the TIMEOUT cycle wins: normal capture, rsp_timeout=0.
REQ-026 RSP: rsp_valid=1, rsp_* stable until rsp_ready; on handshake rsp_valid=0 next cycle, go IDLE.
REQ-027 No cmdN_ready outside IDLE; minimum command-to-command spacing is one IDLE cycle.
REQ-028 m_ack or m_result_rdy in IDLE or RSP ignored, no state change.
REQ-029 Latency: accept cycle -> m_req next cycle; m_result_rdy cycle -> rsp_valid next cycle.

Reset
REQ-030 rst_n low: state IDLE, rr pointer 0, counter 0, m_req 0, m_arg_* 0, rsp_valid 0, all rsp_* 0, busy 0, regardless of clk.
REQ-031 Reset asserted mid-operation drops m_req and rsp_valid immediately; no response is produced for the aborted command.
REQ-032 First rising clk after rst_n deassertion samples IDLE inputs normally.

Verification
REQ-033 Requester 0 only, a=0x7FFF, b=0x7FFF, correct parities; model returns 0x3FFF0001 -> rsp_valid, rsp_id=0, rsp_result=0x3FFF0001, rsp_timeout=0.
REQ-034 Both valid same cycle, repeated 4 commands each -> grants alternate 0,1,0,1...; each rsp_id matches grant order.
REQ-035 a=0x8000 with wrong parity, model asserts m_arg_parity_error -> rsp_parity_error=1, rsp_result as returned.
REQ-036 TIMEOUT=8, model never asserts m_result_rdy -> m_req drops, rsp_valid with rsp_timeout=1, rsp_result=0, exactly 8 cycles after REQ entry.
REQ-037 rsp_ready held low 5 cycles -> rsp_* stable, cmd ready never asserted, busy=1 throughout.
REQ-038 rst_n pulsed low during WAIT -> outputs zero same cycle, no rsp_valid, next command from requester 0 served normally.
